multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Parametrised successor to the CPU control FSM for the ternary core.
- Sequences fetch, register load, ALU, memory load/store, register store and next-PC.
- New versus the fixed-latency version:
  - variable-latency memory and ALU, via ready/done handshakes with a bounded wait timeout;
  - one-hot decoded instruction classes instead of raw opcode compares;
  - halt cause reporting;
  - single-step mode;
  - optional performance counters.

Parameters:
- TIMEOUT_CYCLES, 16, maximum wait cycles in FETCH/ALU/LOAD/STORE before a fault halt; 0 disables the timeout.
- WAIT_WIDTH, 8, width of the internal wait counter; must hold TIMEOUT_CYCLES.
- COUNTER_WIDTH, 32, width of the performance counters.
- ALU_MULTICYCLE, 1, 1 = ALU waits for alu_done; 0 = ALU state lasts exactly one cycle and alu_done is ignored.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- execute  in  1  high enables state advance; low freezes state and all counters.
- soft_reset  in  1  synchronous restart to RESET; clears halt.
- step_mode  in  1  high pauses after each retired instruction.
- step  in  1  rising edge releases one instruction in step mode.
- is_alu_operation, is_load, is_store, is_reg_write, is_branch, is_halt  in  1 each  decoded instruction class; exactly one must be set.
- mem_ready  in  1  memory completes the current fetch/load/store this cycle.
- alu_done  in  1  ALU result is valid this cycle.
- do_fetch, do_reg_load, do_alu, do_mem_load, do_mem_store, do_reg_store, do_next  out  1 each  state strobes, held level for the whole state.
- do_reset  out  1  high in RESET or while reset_n is low.
- do_halt  out  1  high in HALT.
- state  out  4  current state encoding.
- halt_cause  out  2  0 none, 1 HALT instruction, 2 illegal decode, 3 wait timeout.
- cycle_count  out  COUNTER_WIDTH  executing cycles.
- retired_count  out  COUNTER_WIDTH  retired instructions.

Behaviour:
- State encoding: RESET=0, FETCH=1, REGLOAD=2, ALU=3, LOAD=4, STORE=5, REGSTORE=6, NEXT=7, HALT=8, PAUSE=9. Codes 10-15 are unreachable; if entered, next state is HALT with cause 2.
- Async reset (reset_n low): state=RESET, halt_cause=0, wait counter=0, counters=0, step edge register=0. Output do_reset=1; all other do_* = 0.
- Priority, highest first: reset_n, then soft_reset, then execute. soft_reset while execute is low still takes effect.
- execute low: state, wait counter and counters hold; do_fetch..do_next forced to 0. do_reset and do_halt still reflect state.
- Transitions when execute is high:
  - RESET→FETCH.
  - FETCH: mem_ready→REGLOAD.
  - REGLOAD, decode checked in this order:
    - class bits not one-hot → HALT, cause 2;
    - is_halt → HALT, cause 1;
    - is_alu_operation → ALU;
    - is_load → LOAD;
    - is_store → STORE;
    - is_reg_write → REGSTORE;
    - is_branch → NEXT.
  - ALU: alu_done (or always, when ALU_MULTICYCLE=0) → REGSTORE.
  - LOAD: mem_ready→REGSTORE.
  - STORE: mem_ready→NEXT.
  - REGSTORE→NEXT.
  - NEXT: retired_count increments; step_mode high → PAUSE, else FETCH.
  - PAUSE: on a step rising edge (step high and previous sample low) → FETCH. Clearing step_mode while in PAUSE also → FETCH.
  - HALT is sticky; only reset_n or soft_reset leave it.
- Wait counter:
  - Cleared on every state change.
  - Increments each executing cycle spent in FETCH/ALU/LOAD/STORE without completion.
  - If completion is absent and the counter equals TIMEOUT_CYCLES-1 → HALT, cause 3.
  - If completion and timeout coincide, completion wins.
  - A 1-cycle response (ready in the first cycle) never counts.
- halt_cause is written only on entry to HALT and holds until reset.
- Outputs are combinational from the registered state. Entering HALT is one cycle after the deciding edge.
- Fixed latencies, in cycles:
  - ALU instruction with 1-cycle memory and 1-cycle ALU: 5 (FETCH, REGLOAD, ALU, REGSTORE, NEXT).
  - Load: 5.
  - Store: 4.
  - Branch: 3.

Optional Feature:
- Macro CONTROL_PERF_COUNTERS_EN.
- Defined:
  - cycle_count increments every cycle with execute high and state not HALT/PAUSE.
  - retired_count increments in NEXT.
  - Both saturate at all-ones and clear on reset_n or soft_reset.
- Undefined: no counter registers; cycle_count and retired_count are tied to 0.

Test Plan:
- ALU instruction, mem_ready held high, alu_done asserted 3 cycles after ALU entry → ALU lasts 4 cycles; state sequence 1,2,3,3,3,3,6,7,1; retired_count=1.
- Load with mem_ready low for 5 cycles, TIMEOUT_CYCLES=16 → LOAD held 6 cycles with do_mem_load high throughout, then REGSTORE; halt_cause=0.
- TIMEOUT_CYCLES=8, mem_ready stuck low in FETCH → HALT after 8 FETCH cycles; halt_cause=3; do_halt=1; soft_reset pulse → RESET, then FETCH, halt_cause=0.
- REGLOAD with is_load=1 and is_store=1 → HALT, cause 2; with only is_halt=1 → HALT, cause 1; state stays 8 for 20 cycles.
- step_mode=1, two branch instructions → state parks at 9 after each NEXT. The first step pulse releases only one instruction; step held high does not release a second.
- reset_n driven low asynchronously mid-LOAD wait with execute low → immediate state=0, do_reset=1, counters 0. After release, execute low for 10 cycles → state and counters hold.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Decode-class, completion and state-strobe bundle between the control FSM and its datapath.
// Zero latency; pure wiring. Handshakes are level-based: mem_ready and alu_done complete the
// current wait state and may be held low indefinitely, bounded only by the FSM timeout.
interface multicycle_control_if;
    logic is_alu_operation;
    logic is_load;
    logic is_store;
    logic is_reg_write;
    logic is_branch;
    logic is_halt;
    logic mem_ready;
    logic alu_done;
    logic do_fetch;
    logic do_reg_load;
    logic do_alu;
    logic do_mem_load;
    logic do_mem_store;
    logic do_reg_store;
    logic do_next;

    modport master (
        input  is_alu_operation, is_load, is_store, is_reg_write, is_branch, is_halt,
        input  mem_ready, alu_done,
        output do_fetch, do_reg_load, do_alu, do_mem_load, do_mem_store, do_reg_store, do_next
    );

    modport slave (
        output is_alu_operation, is_load, is_store, is_reg_write, is_branch, is_halt,
        output mem_ready, alu_done,
        input  do_fetch, do_reg_load, do_alu, do_mem_load, do_mem_store, do_reg_store, do_next
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with variable-latency memory/ALU waits, halt cause and single-step.
// Outputs combinational from registered state; ALU 5, load 5, store 4, branch 3 cycles at 1-cycle
// memory. Waits on mem_ready/alu_done, faults after TIMEOUT_CYCLES. Counters: CONTROL_PERF_COUNTERS_EN.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WAIT_WIDTH     = 8,
    parameter int COUNTER_WIDTH  = 32,
    parameter int ALU_MULTICYCLE = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     execute,
    input  logic                     soft_reset,
    input  logic                     step_mode,
    input  logic                     step,
    multicycle_control_if.master     bus,
    output logic                     do_reset,
    output logic                     do_halt,
    output logic [3:0]               state,
    output logic [1:0]               halt_cause,
    output logic [COUNTER_WIDTH-1:0] cycle_count,
    output logic [COUNTER_WIDTH-1:0] retired_count
);
    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_REGLOAD  = 4'd2,
        ST_ALU      = 4'd3,
        ST_LOAD     = 4'd4,
        ST_STORE    = 4'd5,
        ST_REGSTORE = 4'd6,
        ST_NEXT     = 4'd7,
        ST_HALT     = 4'd8,
        ST_PAUSE    = 4'd9
    } state_t;

    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [1:0]            halt_cause_q, halt_cause_d;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic                  step_prev_q, step_prev_d;
    logic [5:0]            class_vec;
    logic                  class_onehot;
    logic                  wait_expired;
    logic                  alu_complete;
    logic                  in_wait_state;

    assign class_vec    = {bus.is_halt, bus.is_branch, bus.is_reg_write,
                           bus.is_store, bus.is_load, bus.is_alu_operation};
    assign class_onehot = (class_vec != 6'd0) && ((class_vec & (class_vec - 6'd1)) == 6'd0);
    assign wait_expired = (TIMEOUT_CYCLES != 0) && (wait_q == WAIT_LAST);
    assign alu_complete = (ALU_MULTICYCLE == 0) || bus.alu_done;
    assign in_wait_state = (state_q == ST_FETCH) || (state_q == ST_ALU) ||
                           (state_q == ST_LOAD)  || (state_q == ST_STORE);

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        wait_d       = wait_q;
        step_prev_d  = step;
        if (soft_reset) begin
            state_d      = ST_RESET;
            halt_cause_d = 2'd0;
            wait_d       = '0;
        end else if (execute) begin
            case (state_q)
                ST_RESET:    state_d = ST_FETCH;
                ST_FETCH: begin
                    if (bus.mem_ready)  state_d = ST_REGLOAD;
                    else if (wait_expired) begin
                        state_d = ST_HALT; halt_cause_d = 2'd3;
                    end
                end
                ST_REGLOAD: begin
                    if (!class_onehot) begin
                        state_d = ST_HALT; halt_cause_d = 2'd2;
                    end else if (bus.is_halt) begin
                        state_d = ST_HALT; halt_cause_d = 2'd1;
                    end else if (bus.is_alu_operation) state_d = ST_ALU;
                    else if (bus.is_load)              state_d = ST_LOAD;
                    else if (bus.is_store)             state_d = ST_STORE;
                    else if (bus.is_reg_write)         state_d = ST_REGSTORE;
                    else                               state_d = ST_NEXT;
                end
                ST_ALU: begin
                    if (alu_complete)   state_d = ST_REGSTORE;
                    else if (wait_expired) begin
                        state_d = ST_HALT; halt_cause_d = 2'd3;
                    end
                end
                ST_LOAD: begin
                    if (bus.mem_ready)  state_d = ST_REGSTORE;
                    else if (wait_expired) begin
                        state_d = ST_HALT; halt_cause_d = 2'd3;
                    end
                end
                ST_STORE: begin
                    if (bus.mem_ready)  state_d = ST_NEXT;
                    else if (wait_expired) begin
                        state_d = ST_HALT; halt_cause_d = 2'd3;
                    end
                end
                ST_REGSTORE: state_d = ST_NEXT;
                ST_NEXT:     state_d = step_mode ? ST_PAUSE : ST_FETCH;
                ST_PAUSE: begin
                    if (!step_mode || (step && !step_prev_q)) state_d = ST_FETCH;
                end
                ST_HALT:     state_d = ST_HALT;
                default: begin
                    state_d = ST_HALT; halt_cause_d = 2'd2;
                end
            endcase
            // Only a stall in a wait state accumulates; any state change restarts the count.
            if ((state_d == state_q) && in_wait_state) wait_d = wait_q + 1'b1;
            else                                       wait_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RESET;
            halt_cause_q <= 2'd0;
            wait_q       <= '0;
            step_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            wait_q       <= wait_d;
            step_prev_q  <= step_prev_d;
        end
    end

`ifdef CONTROL_PERF_COUNTERS_EN
    logic [COUNTER_WIDTH-1:0] cycle_q, cycle_d;
    logic [COUNTER_WIDTH-1:0] retired_q, retired_d;

    always_comb begin
        cycle_d   = cycle_q;
        retired_d = retired_q;
        if (soft_reset) begin
            cycle_d   = '0;
            retired_d = '0;
        end else if (execute) begin
            if ((state_q != ST_HALT) && (state_q != ST_PAUSE) && (cycle_q != '1))
                cycle_d = cycle_q + 1'b1;
            if ((state_q == ST_NEXT) && (retired_q != '1))
                retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
`else
    assign cycle_count   = '0;
    assign retired_count = '0;
`endif

    assign bus.do_fetch     = execute && (state_q == ST_FETCH);
    assign bus.do_reg_load  = execute && (state_q == ST_REGLOAD);
    assign bus.do_alu       = execute && (state_q == ST_ALU);
    assign bus.do_mem_load  = execute && (state_q == ST_LOAD);
    assign bus.do_mem_store = execute && (state_q == ST_STORE);
    assign bus.do_reg_store = execute && (state_q == ST_REGSTORE);
    assign bus.do_next      = execute && (state_q == ST_NEXT);
    assign do_reset         = !reset_n || (state_q == ST_RESET);
    assign do_halt          = (state_q == ST_HALT);
    assign state            = state_q;
    assign halt_cause       = halt_cause_q;
endmodule
